// File: rtl/data_bus_arbiter_if.sv
// Bus between the cores, the round-robin read arbiter and the data memory.
// The arbiter takes the slave view; the cores and memory take the master view.
interface data_bus_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
);
    localparam int GID_W = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0]        req;
    logic [NUM_CORES*ADDR_W-1:0] addr_in;
    logic [NUM_CORES-1:0]        ack;
    logic [DATA_W-1:0]           rdata;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_data;
    logic                        busy;
    logic [GID_W-1:0]            grant_id;

    modport slave (
        input  req, addr_in, mem_data,
        output ack, rdata, mem_addr, busy, grant_id
    );

    modport master (
        output req, addr_in, mem_data,
        input  ack, rdata, mem_addr, busy, grant_id
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Round-robin read arbiter in front of a single-port, combinational-read data
// memory. One access takes two cycles: IDLE picks a winner and registers its
// address, READ captures the memory data and pulses that core's ack.
module data_bus_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    data_bus_arbiter_if.slave bus
);
    localparam int GID_W = $clog2(NUM_CORES);

    typedef enum logic {IDLE, READ} state_t;

    state_t               state;
    logic [GID_W-1:0]     rr_ptr;
    logic [NUM_CORES-1:0] eligible;
    logic                 any_eligible;
    logic [GID_W-1:0]     winner;
    logic [ADDR_W-1:0]    winner_addr;
    logic [GID_W-1:0]     next_ptr;

    // The core being acked this cycle still has req high; mask it so it is
    // not served twice for one request.
    assign eligible    = bus.req & ~bus.ack;
    assign winner_addr = bus.addr_in[winner*ADDR_W +: ADDR_W];
    assign next_ptr    = (bus.grant_id == GID_W'(NUM_CORES - 1)) ? '0
                                                                  : bus.grant_id + GID_W'(1);

    // Find the first eligible core at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would infer a latch.
        any_eligible = 1'b0;
        winner       = '0;
        idx          = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!any_eligible && eligible[idx]) begin
                any_eligible = 1'b1;
                winner       = GID_W'(idx);
            end
        end
    end

    // Two-state access FSM with all outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state        <= IDLE;
            bus.ack      <= '0;
            bus.rdata    <= '0;
            bus.mem_addr <= '0;
            bus.busy     <= 1'b0;
            bus.grant_id <= '0;
            rr_ptr       <= '0;
        end else begin
            bus.ack <= '0;
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        bus.mem_addr <= winner_addr;
                        bus.grant_id <= winner;
                        bus.busy     <= 1'b1;
                        state        <= READ;
                    end
                end
                READ: begin
                    bus.rdata <= bus.mem_data;
                    bus.ack   <= NUM_CORES'(1) << bus.grant_id;
                    rr_ptr    <= next_ptr;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios plus a
// randomized run against a behavioural round-robin model. Memory returns the
// inverted address.
module tb_data_bus_arbiter;
    localparam int N = 4;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    data_bus_arbiter_if #(.NUM_CORES(N), .ADDR_W(8), .DATA_W(8)) bus ();

    assign bus.mem_data = ~bus.mem_addr;

    data_bus_arbiter #(.NUM_CORES(N), .ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_addr(input int k, input logic [7:0] a);
        bus.addr_in[k*8 +: 8] = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        bus.addr_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req = 4'b1111;
        set_addr(0, 8'h5A); set_addr(1, 8'h03); set_addr(2, 8'hFF); set_addr(3, 8'h10);
        repeat (2) @(negedge clk);
        if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset ack: got %b want 0000", bus.ack); end
        n_checks++;
        if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset rdata: got %h want 00", bus.rdata); end
        n_checks++;
        if (bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset mem_addr: got %h want 00", bus.mem_addr); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        n_checks++;
        if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset grant_id: got %0d want 0", bus.grant_id); end
        n_checks++;
        reset = 1'b0;
        step();
        if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1 || bus.mem_addr !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset first grant: got id=%0d busy=%b addr=%h want id=0 busy=1 addr=5a",
                     bus.grant_id, bus.busy, bus.mem_addr);
        end
        n_checks++;
        step();
        if (bus.ack !== 4'b0001 || bus.rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset first ack: got ack=%b rdata=%h want 0001/a5", bus.ack, bus.rdata);
        end
        n_checks++;
        bus.req = '0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0100;
        set_addr(2, 8'h0C);
        step();
        if (bus.mem_addr !== 8'h0C || bus.grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single grant: got addr=%h id=%0d want 0c/2", bus.mem_addr, bus.grant_id);
        end
        n_checks++;
        if (bus.busy !== 1'b1 || bus.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL single read phase: got busy=%b ack=%b want 1/0000", bus.busy, bus.ack);
        end
        n_checks++;
        step();
        if (bus.ack !== 4'b0100 || bus.rdata !== 8'hF3) begin
            n_fail++;
            $display("FAIL single ack: got ack=%b rdata=%h want 0100/f3", bus.ack, bus.rdata);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single busy drop: got %b want 0", bus.busy); end
        n_checks++;
        bus.req = '0;
        step();
        if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.rdata !== 8'hF3) begin
            n_fail++;
            $display("FAIL single after: got ack=%b busy=%b rdata=%h want 0000/0/f3", bus.ack, bus.busy, bus.rdata);
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_d [5] = '{8'hFF, 8'hFC, 8'h00, 8'hEF, 8'hFF};
        logic [3:0] one;
        do_reset();
        bus.req = 4'b1111;
        set_addr(0, 8'h00); set_addr(1, 8'h03); set_addr(2, 8'hFF); set_addr(3, 8'h10);
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.busy !== 1'b1 || bus.grant_id !== 2'(order[k]) || bus.ack !== 4'b0000) begin
                n_fail++;
                $display("FAIL b2b grant %0d: got busy=%b id=%0d ack=%b want 1/%0d/0000",
                         k, bus.busy, bus.grant_id, bus.ack, order[k]);
            end
            n_checks++;
            step();
            one = 4'b0001 << order[k];
            if (bus.ack !== one || bus.rdata !== exp_d[k]) begin
                n_fail++;
                $display("FAIL b2b ack %0d: got ack=%b rdata=%h want %b/%h", k, bus.ack, bus.rdata, one, exp_d[k]);
            end
            n_checks++;
        end
        bus.req = '0;
        step();
    endtask

    task automatic test_wrap_mask();
        do_reset();
        bus.req = 4'b0100;
        set_addr(2, 8'h22);
        repeat (2) step();
        // core2 served, rr_ptr now 3
        bus.req = 4'b1001;
        set_addr(3, 8'h55); set_addr(0, 8'hAA);
        step();
        if (bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL wrap first grant: got %0d want 3", bus.grant_id); end
        n_checks++;
        step();
        if (bus.ack !== 4'b1000 || bus.rdata !== 8'hAA) begin
            n_fail++;
            $display("FAIL wrap ack3: got ack=%b rdata=%h want 1000/aa", bus.ack, bus.rdata);
        end
        n_checks++;
        step();
        if (bus.grant_id !== 2'd0 || bus.mem_addr !== 8'hAA) begin
            n_fail++;
            $display("FAIL mask second grant: got id=%0d addr=%h want 0/aa", bus.grant_id, bus.mem_addr);
        end
        n_checks++;
        step();
        if (bus.ack !== 4'b0001 || bus.rdata !== 8'h55) begin
            n_fail++;
            $display("FAIL mask ack0: got ack=%b rdata=%h want 0001/55", bus.ack, bus.rdata);
        end
        n_checks++;
        bus.req = '0;
        step();
    endtask

    task automatic test_violation();
        do_reset();
        bus.req = 4'b0010;
        set_addr(1, 8'h3C);
        step();
        bus.req = '0;
        set_addr(1, 8'h77);
        step();
        if (bus.ack !== 4'b0010 || bus.rdata !== 8'hC3) begin
            n_fail++;
            $display("FAIL violation ack: got ack=%b rdata=%h want 0010/c3", bus.ack, bus.rdata);
        end
        n_checks++;
        step();
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.req = 4'b0010;
        set_addr(1, 8'h01);
        repeat (2) step();
        bus.req = 4'b1111;
        set_addr(0, 8'h40); set_addr(2, 8'h42); set_addr(3, 8'h43);
        step();
        if (bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL midreset pre grant: got %0d want 2", bus.grant_id); end
        n_checks++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.mem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset abort: got ack=%b busy=%b addr=%h want 0000/0/00", bus.ack, bus.busy, bus.mem_addr);
        end
        n_checks++;
        step();
        if (bus.grant_id !== 2'd0 || bus.mem_addr !== 8'h40) begin
            n_fail++;
            $display("FAIL midreset ptr: got id=%0d addr=%h want 0/40", bus.grant_id, bus.mem_addr);
        end
        n_checks++;
        step();
        if (bus.ack !== 4'b0001 || bus.rdata !== 8'hBF) begin
            n_fail++;
            $display("FAIL midreset ack: got ack=%b rdata=%h want 0001/bf", bus.ack, bus.rdata);
        end
        n_checks++;
        bus.req = '0;
        step();
    endtask

    // Reference: an access is granted to the first requesting core (not the
    // one being acked) counting upward from the core after the last one
    // served, completes one cycle later with data = ~address.
    task automatic test_random();
        logic [3:0] m_req   = '0;
        logic [3:0] m_ack   = '0;
        logic [3:0] elig;
        logic [7:0] m_addr  = '0;
        logic [7:0] m_rdata = '0;
        logic [7:0] addr [N];
        logic       m_busy  = 1'b0;
        bit         pending_done = 1'b0;
        int         m_next  = 0;
        int         m_gid   = 0;
        int         c;
        for (int k = 0; k < N; k++) addr[k] = '0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (bus.ack !== m_ack || bus.busy !== m_busy || bus.rdata !== m_rdata ||
                bus.mem_addr !== m_addr || bus.grant_id !== 2'(m_gid)) begin
                n_fail++;
                $display("FAIL random cycle %0d: got ack=%b busy=%b rdata=%h addr=%h id=%0d want %b/%b/%h/%h/%0d",
                         cyc, bus.ack, bus.busy, bus.rdata, bus.mem_addr, bus.grant_id,
                         m_ack, m_busy, m_rdata, m_addr, m_gid);
            end
            n_checks++;
            for (int k = 0; k < N; k++) begin
                if (m_req[k] && m_ack[k]) begin
                    if ($urandom_range(1) == 0) m_req[k] = 1'b0;
                    else addr[k] = 8'($urandom);
                end else if (!m_req[k] && $urandom_range(2) == 0) begin
                    m_req[k] = 1'b1;
                    addr[k]  = 8'($urandom);
                end
                set_addr(k, addr[k]);
            end
            bus.req = m_req;
            if (pending_done) begin
                m_rdata = ~m_addr;
                m_ack = 4'b0001 << m_gid;
                m_next = (m_gid + 1) % N;
                m_busy = 1'b0;
                pending_done = 1'b0;
            end else begin
                elig = m_req & ~m_ack;
                m_ack = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    c = (m_next + i) % N;
                    if (elig[c]) m_gid = c;
                end
                if (elig != 0) begin
                    m_addr = addr[m_gid];
                    m_busy = 1'b1;
                    pending_done = 1'b1;
                end
            end
            step();
        end
        bus.req = '0;
        step();
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        bus.req = '0;
        bus.addr_in = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap_mask();
        test_violation();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Round-robin arbiter placed directly upstream of the single-port, combinational-read data memory in the multicore build.
- Lets NUM_CORES cores share one address bus: it picks one requester, drives that core's address to the memory, registers the returned byte, and acknowledges that core.
- The block is read-only; no writes pass through it.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 8, address width.
- DATA_W, 8, data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_CORES  per-core read request, level-held until acked.
- addr_in  input  NUM_CORES*ADDR_W  packed per-core addresses; core k uses bits [k*ADDR_W +: ADDR_W].
- ack  output  NUM_CORES  one-hot, one-cycle pulse marking rdata valid for that core.
- rdata  output  DATA_W  registered read data, broadcast to all cores.
- mem_addr  output  ADDR_W  registered address to the memory address bus.
- mem_data  input  DATA_W  combinational read data from memory.
- busy  output  1  high while an access is in flight (state READ).
- grant_id  output  clog2(NUM_CORES)  index of the current or last granted core.

Behaviour:
- Reset (synchronous, active-high) sets: state=IDLE, ack=0, rdata=0, mem_addr=0, busy=0, grant_id=0, rr_ptr=0.
- Reset asserted mid-access aborts the access. No ack is issued for it, and the core must re-request after reset.
- Two-state FSM:
  - IDLE:
    - eligible = req & ~ack (the core being acked this cycle is masked, so a still-high req is never double-served).
    - If eligible is nonzero: winner = first set bit at or after rr_ptr, searching upward with wrap modulo NUM_CORES.
    - On the edge: mem_addr<=addr_in[winner], grant_id<=winner, -> READ.
    - Otherwise stay in IDLE; mem_addr holds its value.
  - READ:
    - On the edge: rdata<=mem_data, ack<=onehot(grant_id), rr_ptr<=(grant_id+1) mod NUM_CORES, -> IDLE.
- ack is 0 at every other edge; each pulse lasts exactly one cycle.
- Latency: req first sampled high at edge E0 (IDLE) -> mem_addr valid after E0 -> ack and rdata valid after E1.
- Throughput: one access per 2 cycles. A new grant can occur at the same edge that clears ack.
- rdata holds its value until the next READ edge.
- Protocol:
  - A core holds req and its address stable from assertion until it sees ack.
  - The core drops req in the cycle after ack, or keeps it high to request again; the re-request is served no earlier than the next IDLE evaluation.
- req dropped during READ is a protocol violation. The access still completes and ack still pulses.
- addr_in changing during READ has no effect, because mem_addr is already registered.
- Fairness: a continuously requesting core waits at most NUM_CORES-1 other grants.
- rr_ptr wraps from NUM_CORES-1 to 0.
- Every eligible request is eventually served, with no starvation.

Test Plan:
Memory model for all scenarios: mem_data = ~mem_addr.
- Reset: hold reset=1 for 2 cycles with req=4'b1111 -> ack=0, rdata=0, mem_addr=0, busy=0. After release, core0 is granted first (rr_ptr=0).
- Single request: core2 req with addr 8'h0C -> mem_addr=8'h0C after E0; ack=4'b0100 and rdata=8'hF3 after E1; busy high for exactly 1 cycle.
- All request continuously: req=4'b1111, addresses 8'h00/8'h03/8'hFF/8'h10 -> grant order 0,1,2,3,0. rdata sequence FF, FC, 00, EF, FF; an ack every 2 cycles.
- Wrap and mask: rr_ptr=3, req=4'b1001 -> core3 served, then core0. Core3 keeps req high through its ack cycle -> it is not regranted until after core0.
- Violation: core1 drops req during READ -> ack[1] still pulses and rdata is valid.
- Mid-access reset: assert reset in the READ cycle -> no ack. Next state is IDLE with rr_ptr=0.
